fc_output_classifier: RTL and testbench

- Sits directly downstream of the fully connected layer and consumes its 10-element Q8.8 result vector on the layer's single-cycle valid pulse.
- Applies ReLU to produce an activated vector and performs a sequential signed argmax, one element per cycle.
- Holds the classification result under a valid/ready handshake toward the consumer (test harness or next layer).
- Counts result vectors dropped because the block was busy.

---
 rtl/fc_output_classifier.sv | 170 +++++++++++++++++
 tb/tb_fc_output_classifier.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_output_classifier.sv
// ReLU + sequential signed argmax over the fully connected layer's result vector, result held under valid/ready.
// Optional best-minus-second margin output is enabled by defining FC_CLASSIFIER_MARGIN_EN.
module fc_output_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   valid_i,
    input  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] data_i,
    output logic                                   busy_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [IDX_WIDTH-1:0]                   class_o,
    output logic [DATA_WIDTH-1:0]                  max_value_o,
    output logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] relu_data_o,
    output logic [DATA_WIDTH-1:0]                  margin_o,
    output logic [7:0]                             drop_count_o,
    output logic [1:0]                             debug_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0]         LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // FRAC_BITS only describes the Q format; values are compared raw.
    if (((1 << IDX_WIDTH) < NUM_CLASSES) || (FRAC_BITS >= DATA_WIDTH)) begin : g_bad_params
        $error("fc_output_classifier: inconsistent parameters");
    end

    state_t                                 state, state_nxt;
    logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] buf_q;
    logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0] relu_q;
    logic [IDX_WIDTH-1:0]                   idx_q, best_idx_q, best_idx_nxt;
    logic signed [DATA_WIDTH-1:0]           cur, best_q, best_nxt;
    logic [IDX_WIDTH-1:0]                   class_q;
    logic [DATA_WIDTH-1:0]                  max_q;
    logic [7:0]                             drop_q;
    logic                                   capture, drop, scan_last;

    assign cur       = $signed(buf_q[idx_q]);
    assign scan_last = (state == SCAN) && (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // valid_o is high exactly in HOLD; a cycle with valid_o && ready_i transfers the result,
    // and a new valid_i in that same cycle is captured rather than dropped.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    capture   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                drop = valid_i;
                if (scan_last) state_nxt = HOLD;
            end
            HOLD: begin
                if (ready_i) begin
                    capture   = valid_i;
                    state_nxt = valid_i ? SCAN : IDLE;
                end else begin
                    drop = valid_i;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_nxt     = best_q;
        best_idx_nxt = best_idx_q;
        if (cur > best_q) begin
            best_nxt     = cur;
            best_idx_nxt = idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            relu_q     <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            class_q    <= '0;
            max_q      <= '0;
        end else if (capture) begin
            buf_q      <= data_i;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= MOST_NEG;
        end else if (state == SCAN) begin
            relu_q[idx_q] <= (cur > 0) ? cur : '0;
            best_q        <= best_nxt;
            best_idx_q    <= best_idx_nxt;
            idx_q         <= idx_q + 1'b1;
            if (scan_last) begin
                class_q <= best_idx_nxt;
                max_q   <= best_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      drop_q <= '0;
        else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end

`ifdef FC_CLASSIFIER_MARGIN_EN
    localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic signed [DATA_WIDTH-1:0] second_q, second_nxt;
    logic signed [DATA_WIDTH:0]   margin_wide;
    logic [DATA_WIDTH-1:0]        margin_q;

    // A new best demotes the old one; a value equal to best still qualifies as second.
    always_comb begin
        second_nxt = second_q;
        if (cur > best_q)        second_nxt = best_q;
        else if (cur > second_q) second_nxt = cur;
    end

    assign margin_wide = {best_nxt[DATA_WIDTH-1], best_nxt} - {second_nxt[DATA_WIDTH-1], second_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            second_q <= '0;
            margin_q <= '0;
        end else if (capture) begin
            second_q <= MOST_NEG;
        end else if (state == SCAN) begin
            second_q <= second_nxt;
            if (scan_last) begin
                margin_q <= (margin_wide[DATA_WIDTH:DATA_WIDTH-1] != 2'b00) ? MAX_POS
                                                                             : margin_wide[DATA_WIDTH-1:0];
            end
        end
    end

    assign margin_o = margin_q;
`else
    assign margin_o = '0;
`endif

    assign busy_o        = (state != IDLE);
    assign valid_o       = (state == HOLD);
    assign class_o       = class_q;
    assign max_value_o   = max_q;
    assign relu_data_o   = relu_q;
    assign drop_count_o  = drop_q;
    assign debug_state_o = state;

endmodule

// File: tb/tb_fc_output_classifier.sv
// Self-checking bench for fc_output_classifier: directed and randomized vectors against a sort/argmax model.
module tb_fc_output_classifier;
  localparam int NC = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  typedef logic [NC-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  vec_t          data_i = '0;
  logic          busy_o, valid_o;
  logic [IW-1:0] class_o;
  logic [DW-1:0] max_value_o, margin_o;
  vec_t          relu_data_o;
  logic [7:0]    drop_count_o;
  logic [1:0]    debug_state_o;

  int n_checks = 0;
  int n_pass = 0;
  int exp_drop = 0;

  fc_output_classifier dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .data_i(data_i),
    .busy_o(busy_o), .valid_o(valid_o), .ready_i(ready_i),
    .class_o(class_o), .max_value_o(max_value_o), .relu_data_o(relu_data_o),
    .margin_o(margin_o), .drop_count_o(drop_count_o), .debug_state_o(debug_state_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int exp_class(input vec_t v);
    int b = 0;
    for (int k = 1; k < NC; k++)
      if ($signed(v[k]) > $signed(v[b])) b = k;
    return b;
  endfunction

  function automatic vec_t exp_relu(input vec_t v);
    vec_t r;
    for (int k = 0; k < NC; k++) r[k] = ($signed(v[k]) > 0) ? v[k] : '0;
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_margin(input vec_t v);
`ifdef FC_CLASSIFIER_MARGIN_EN
    int q[$];
    int d;
    for (int k = 0; k < NC; k++) q.push_back(int'($signed(v[k])));
    q.rsort();
    d = q[0] - q[1];
    if (d > 32767) d = 32767;
    return DW'(d);
`else
    return '0;
`endif
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < NC; k++) begin
      case ($urandom_range(0, 6))
        0: v[k] = 16'h8000;
        1: v[k] = 16'h7FFF;
        2: v[k] = 16'h0000;
        3: v[k] = 16'hFF80;
        default: v[k] = 16'($urandom());
      endcase
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input vec_t v, input logic rdy);
    @(negedge clk);
    data_i = v; valid_i = 1'b1; ready_i = rdy;
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (valid_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, valid_o, class_o, max_value_o, margin_o, drop_count_o, debug_state_o} !== '0)
      $display("FAIL reset_outputs: busy=%b valid=%b class=%0d max=%h margin=%h drop=%0d state=%0d, want all 0",
               busy_o, valid_o, class_o, max_value_o, margin_o, drop_count_o, debug_state_o);
    else n_pass++;
    n_checks++;
    if (relu_data_o !== '0) $display("FAIL reset_relu: got %h want 0", relu_data_o);
    else n_pass++;
  endtask

  task automatic test_directed();
    vec_t v;
    int k;
    for (int t = 0; t < 3; t++) begin
      v = '0;
      case (t)
        0: begin v[0] = 16'h0100; v[1] = 16'hFF00; v[2] = 16'h0300; v[3] = 16'h0050; end
        1: for (int j = 0; j < NC; j++) v[j] = 16'hFF80;
        default: begin v[3] = 16'h0400; v[7] = 16'h0400; end
      endcase
      send(v, 1'b0);
      n_checks++;
      if (busy_o !== 1'b1 || debug_state_o !== 2'd1)
        $display("FAIL dir%0d_scan_state: busy=%b state=%0d want busy=1 state=1", t, busy_o, debug_state_o);
      else n_pass++;
      wait_valid(k);
      n_checks++;
      if (k != NC) $display("FAIL dir%0d_latency: got %0d cycles want %0d", t, k, NC);
      else n_pass++;
      n_checks++;
      if (debug_state_o !== 2'd2) $display("FAIL dir%0d_hold_state: got %0d want 2", t, debug_state_o);
      else n_pass++;
      n_checks++;
      if (class_o !== IW'(exp_class(v))) $display("FAIL dir%0d_class: got %0d want %0d", t, class_o, exp_class(v));
      else n_pass++;
      n_checks++;
      if (max_value_o !== v[exp_class(v)]) $display("FAIL dir%0d_max: got %h want %h", t, max_value_o, v[exp_class(v)]);
      else n_pass++;
      n_checks++;
      if (relu_data_o !== exp_relu(v)) $display("FAIL dir%0d_relu: got %h want %h", t, relu_data_o, exp_relu(v));
      else n_pass++;
      n_checks++;
      if (margin_o !== exp_margin(v)) $display("FAIL dir%0d_margin: got %h want %h", t, margin_o, exp_margin(v));
      else n_pass++;
      consume();
      n_checks++;
      if (valid_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL dir%0d_release: valid=%b busy=%b want 0 0", t, valid_o, busy_o);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    vec_t v;
    int k;
    for (int t = 0; t < 25; t++) begin
      v = rand_vec();
      send(v, 1'($urandom_range(0, 1)));
      wait_valid(k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_checks++;
      if (k != NC || valid_o !== 1'b1)
        $display("FAIL rnd%0d_latency: got %0d cycles valid=%b want %0d 1", t, k, valid_o, NC);
      else n_pass++;
      n_checks++;
      if (class_o !== IW'(exp_class(v)) || max_value_o !== v[exp_class(v)])
        $display("FAIL rnd%0d_argmax: got %0d/%h want %0d/%h", t, class_o, max_value_o, exp_class(v), v[exp_class(v)]);
      else n_pass++;
      n_checks++;
      if (relu_data_o !== exp_relu(v)) $display("FAIL rnd%0d_relu: got %h want %h", t, relu_data_o, exp_relu(v));
      else n_pass++;
      n_checks++;
      if (margin_o !== exp_margin(v)) $display("FAIL rnd%0d_margin: got %h want %h", t, margin_o, exp_margin(v));
      else n_pass++;
      consume();
    end
  endtask

  task automatic test_back_to_back();
    vec_t a, b;
    int k;
    a = rand_vec();
    b = rand_vec();
    send(a, 1'b0);
    @(negedge clk);
    data_i = rand_vec(); valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    exp_drop++;
    wait_valid(k);
    n_checks++;
    if (class_o !== IW'(exp_class(a))) $display("FAIL b2b_first_class: got %0d want %0d", class_o, exp_class(a));
    else n_pass++;
    n_checks++;
    if (drop_count_o !== 8'(exp_drop)) $display("FAIL b2b_scan_drop: got %0d want %0d", drop_count_o, exp_drop);
    else n_pass++;
    @(negedge clk);
    data_i = b; valid_i = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b0;
    wait_valid(k);
    n_checks++;
    if (k != NC) $display("FAIL b2b_gap: valid low for %0d cycles want %0d", k, NC);
    else n_pass++;
    n_checks++;
    if (class_o !== IW'(exp_class(b)) || max_value_o !== b[exp_class(b)])
      $display("FAIL b2b_second_argmax: got %0d/%h want %0d/%h", class_o, max_value_o, exp_class(b), b[exp_class(b)]);
    else n_pass++;
    n_checks++;
    if (relu_data_o !== exp_relu(b) || margin_o !== exp_margin(b))
      $display("FAIL b2b_second_relu_margin: got %h/%h want %h/%h", relu_data_o, margin_o, exp_relu(b), exp_margin(b));
    else n_pass++;
    n_checks++;
    if (drop_count_o !== 8'(exp_drop)) $display("FAIL b2b_drop_unchanged: got %0d want %0d", drop_count_o, exp_drop);
    else n_pass++;
    consume();
  endtask

  task automatic test_drop_saturation();
    vec_t a;
    a = rand_vec();
    send(a, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      data_i = rand_vec(); valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
    end
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    n_checks++;
    if (drop_count_o !== 8'(exp_drop)) $display("FAIL drop_saturate: got %0d want %0d", drop_count_o, exp_drop);
    else n_pass++;
    n_checks++;
    if (valid_o !== 1'b1 || class_o !== IW'(exp_class(a)) || max_value_o !== a[exp_class(a)])
      $display("FAIL drop_result_held: valid=%b got %0d/%h want 1 %0d/%h",
               valid_o, class_o, max_value_o, exp_class(a), a[exp_class(a)]);
    else n_pass++;
    consume();
    n_checks++;
    if (drop_count_o !== 8'(exp_drop) || valid_o !== 1'b0)
      $display("FAIL drop_after_ready: drop=%0d valid=%b want %0d 0", drop_count_o, valid_o, exp_drop);
    else n_pass++;
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    send(rand_vec(), 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, valid_o, class_o, max_value_o, margin_o, drop_count_o, debug_state_o} !== '0 || relu_data_o !== '0)
      $display("FAIL midscan_reset_outputs: busy=%b valid=%b class=%0d max=%h drop=%0d state=%0d relu=%h want all 0",
               busy_o, valid_o, class_o, max_value_o, drop_count_o, debug_state_o, relu_data_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_drop = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL midscan_no_valid: busy/valid high on %0d cycles want 0", seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_drop_saturation();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
